arya_run_controller: RTL and testbench

Host-side sequencer for the arya core. It owns the core's run/debug controls: en, setup_mem, verify_mem, the port-A memory address and the port-A write data. It serialises three host commands through one FSM:
- LOAD: stream words into unified memory.
- RUN: enable the pipeline for a fixed cycle budget.
- DUMP: read a memory window back out.

It guarantees port A of unified memory is never shared between instruction fetch and host access in the same cycle.

---
 rtl/arya_ctrl_pkg.sv | 26 ++
 rtl/arya_run_controller_if.sv | 33 +++
 rtl/arya_run_controller.sv | 209 ++++++++++++++++++++
 tb/tb_arya_run_controller.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arya_ctrl_pkg.sv
// Shared encodings and default widths for the arya host-side run controller.
package arya_ctrl_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 64;
    localparam int CYC_W_DEF  = 16;
    localparam int RD_LAT_DEF = 1;

    typedef enum logic [1:0] {
        CMD_NOP  = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_RUN  = 2'd2,
        CMD_DUMP = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_D_ISSUE,
        ST_D_WAIT,
        ST_D_HOLD,
        ST_FIN
    } state_e;

endpackage

// File: rtl/arya_run_controller_if.sv
// Host command / write-beat / read-beat channels of the run controller.
interface arya_run_controller_if #(
    parameter int ADDR_W = arya_ctrl_pkg::ADDR_W_DEF,
    parameter int DATA_W = arya_ctrl_pkg::DATA_W_DEF,
    parameter int CYC_W  = arya_ctrl_pkg::CYC_W_DEF
);
    logic [1:0]        host_cmd;
    logic              host_cmd_valid;
    logic              host_cmd_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [ADDR_W-1:0] host_len;
    logic [CYC_W-1:0]  host_cycles;
    logic [DATA_W-1:0] host_wdata;
    logic              host_wvalid;
    logic              host_wready;
    logic [DATA_W-1:0] host_rdata;
    logic              host_rvalid;
    logic              host_rready;

    // Host side drives commands and beats.
    modport master (
        output host_cmd, host_cmd_valid, host_addr, host_len, host_cycles,
               host_wdata, host_wvalid, host_rready,
        input  host_cmd_ready, host_wready, host_rdata, host_rvalid
    );

    // Controller side.
    modport slave (
        input  host_cmd, host_cmd_valid, host_addr, host_len, host_cycles,
               host_wdata, host_wvalid, host_rready,
        output host_cmd_ready, host_wready, host_rdata, host_rvalid
    );
endinterface

// File: rtl/arya_run_controller.sv
// Host-side sequencer for the arya core: serialises LOAD / RUN / DUMP and keeps
// port A of unified memory owned by either the pipeline or the host, never both.
module arya_run_controller
    import arya_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CYC_W  = CYC_W_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    arya_run_controller_if.slave host,
    output logic              busy,
    output logic              done,
    output logic              core_en,
    output logic              core_setup_mem,
    output logic              core_verify_mem,
    output logic [ADDR_W-1:0] core_mem_addr,
    output logic [DATA_W-1:0] core_mem_data,
    input  logic [DATA_W-1:0] core_mem_rdata
);

    localparam int CNT_W  = (ADDR_W > CYC_W) ? ADDR_W : CYC_W;
    localparam int WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    // FSM and shared datapath
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    // Registered outputs
    logic              cmd_ready_q, cmd_ready_d;
    logic              wready_q, wready_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              en_q, en_d;
    logic              setup_q, setup_d;
    logic              verify_q, verify_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    cmd_e cmd;
    logic cmd_fire, w_fire, r_fire, run_nonzero;

    assign cmd         = cmd_e'(host.host_cmd);
    // ready is only ever high in IDLE, so commands arriving while busy are dropped
    assign cmd_fire    = host.host_cmd_valid & cmd_ready_q;
    assign w_fire      = host.host_wvalid & wready_q;
    assign r_fire      = rvalid_q & host.host_rready;
    assign run_nonzero = (host.host_cycles != '0);

    // State register plus registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge value of the others, independent of statement order.
        if (!reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            cmd_ready_q <= 1'b1;
            wready_q    <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            en_q        <= 1'b0;
            setup_q     <= 1'b0;
            verify_q    <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            cmd_ready_q <= cmd_ready_d;
            wready_q    <= wready_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            en_q        <= en_d;
            setup_q     <= setup_d;
            verify_q    <= verify_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
        end
    end

    // Next-state and pointer/counter update
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    unique case (cmd)
                        CMD_LOAD, CMD_DUMP: begin
                            ptr_d = host.host_addr;
                            cnt_d = CNT_W'(host.host_len);
                            if (host.host_len == '0)   state_d = ST_FIN;
                            else if (cmd == CMD_LOAD)  state_d = ST_LOAD;
                            else                       state_d = ST_D_ISSUE;
                        end
                        CMD_RUN: begin
                            // cnt holds the enable cycles still owed after the one being issued
                            if (!run_nonzero) begin
                                state_d = ST_FIN;
                            end else begin
                                cnt_d   = CNT_W'(host.host_cycles) - CNT_W'(1);
                                state_d = (host.host_cycles == CYC_W'(1)) ? ST_FIN : ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (w_fire) begin
                    ptr_d = ptr_q + ADDR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) state_d = ST_FIN;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIN;
            end
            ST_D_ISSUE: begin
                state_d = ST_D_WAIT;
                wait_d  = WAIT_W'(RD_LAT - 1);
            end
            ST_D_WAIT: begin
                if (wait_q == '0) state_d = ST_D_HOLD;
                else              wait_d  = wait_q - WAIT_W'(1);
            end
            ST_D_HOLD: begin
                if (r_fire) begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    cnt_d   = cnt_q - CNT_W'(1);
                    state_d = (cnt_q == CNT_W'(1)) ? ST_FIN : ST_D_ISSUE;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        wready_d    = (state_d == ST_LOAD);
        done_d      = (state_q == ST_FIN);
        en_d        = 1'b0;
        setup_d     = 1'b0;
        verify_d    = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        rdata_d     = rdata_q;
        rvalid_d    = rvalid_q;
        unique case (state_q)
            ST_IDLE:  en_d = cmd_fire && (cmd == CMD_RUN) && run_nonzero;
            ST_RUN:   en_d = 1'b1;
            ST_LOAD: begin
                if (w_fire) begin
                    setup_d = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = host.host_wdata;
                end
            end
            ST_D_WAIT: begin
                if (wait_q == '0) begin
                    rdata_d  = core_mem_rdata;
                    rvalid_d = 1'b1;
                end
            end
            ST_D_HOLD: if (r_fire) rvalid_d = 1'b0;
            default: ;
        endcase
        // Host owns port A from the issue cycle until read data is captured
        if (state_d == ST_D_ISSUE || state_d == ST_D_WAIT) begin
            verify_d = 1'b1;
            addr_d   = ptr_d;
        end
    end

    assign host.host_cmd_ready = cmd_ready_q;
    assign host.host_wready    = wready_q;
    assign host.host_rdata     = rdata_q;
    assign host.host_rvalid    = rvalid_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign core_en             = en_q;
    assign core_setup_mem      = setup_q;
    assign core_verify_mem     = verify_q;
    assign core_mem_addr       = addr_q;
    assign core_mem_data       = data_q;

endmodule

// File: tb/tb_arya_run_controller.sv
// Self-checking bench for arya_run_controller: directed scenarios followed by
// random command sequences, checked against a transaction-level model.
module tb_arya_run_controller;
    import arya_ctrl_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;
    localparam int CYC_W  = 16;
    localparam int RD_LAT = 1;
    localparam int DEPTH  = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy, done, core_en, core_setup_mem, core_verify_mem;
    logic [ADDR_W-1:0] core_mem_addr;
    logic [DATA_W-1:0] core_mem_data;
    logic [DATA_W-1:0] core_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_on   = 1'b0;

    // Fake core memory: written by the DUT, untouched words read as addr^0x55
    logic [DATA_W-1:0] core_mem [DEPTH];
    bit                core_written [DEPTH];
    // Reference image of what memory should hold, maintained per transaction
    logic [DATA_W-1:0] ref_mem [DEPTH];

    arya_run_controller_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W)) hif ();

    arya_run_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W), .RD_LAT(RD_LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .host            (hif),
        .busy            (busy),
        .done            (done),
        .core_en         (core_en),
        .core_setup_mem  (core_setup_mem),
        .core_verify_mem (core_verify_mem),
        .core_mem_addr   (core_mem_addr),
        .core_mem_data   (core_mem_data),
        .core_mem_rdata  (core_mem_rdata)
    );

    always #5 clk = ~clk;

    // Port-A model with one cycle read latency
    always @(posedge clk) begin
        if (core_setup_mem) begin
            core_mem[core_mem_addr]     <= core_mem_data;
            core_written[core_mem_addr] <= 1'b1;
        end
        if (core_verify_mem)
            core_mem_rdata <= core_written[core_mem_addr] ? core_mem[core_mem_addr]
                                                          : (DATA_W'(core_mem_addr) ^ 64'h55);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Port-A exclusion must hold every cycle
    always @(negedge clk) begin
        if (mon_on)
            check("port_a_exclusive",
                  {61'd0, core_en & core_setup_mem, core_en & core_verify_mem,
                   core_setup_mem & core_verify_mem}, 64'd0);
    end

    task automatic clear_inputs();
        hif.host_cmd       = 2'd0;
        hif.host_cmd_valid = 1'b0;
        hif.host_addr      = '0;
        hif.host_len       = '0;
        hif.host_cycles    = '0;
        hif.host_wdata     = '0;
        hif.host_wvalid    = 1'b0;
        hif.host_rready    = 1'b0;
    endtask

    task automatic resync();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Presents one command at a negedge; returns at the negedge of the cycle after acceptance
    task automatic issue(input logic [1:0] cmd, input int addr, input int len, input int cycles);
        check("cmd_ready_idle", hif.host_cmd_ready, 1);
        hif.host_cmd       = cmd;
        hif.host_addr      = ADDR_W'(addr);
        hif.host_len       = ADDR_W'(len);
        hif.host_cycles    = CYC_W'(cycles);
        hif.host_cmd_valid = 1'b1;
        @(negedge clk);
        hif.host_cmd_valid = 1'b0;
        hif.host_cmd       = 2'($urandom);
    endtask

    task automatic expect_done();
        check("done_pulse", done, 1);
        check("done_busy_low", busy, 0);
        check("done_ready_high", hif.host_cmd_ready, 1);
        @(negedge clk);
        check("done_single_cycle", done, 0);
    endtask

    task automatic do_load(input int base, input int len, input int gap_idx, input int gap_n,
                           input bit rnd);
        int g, a;
        logic [DATA_W-1:0] d;
        issue(CMD_LOAD, base, len, 0);
        check("load_busy", busy, 1);
        check("load_ready_low", hif.host_cmd_ready, 0);
        check("load_no_early_write", core_setup_mem, 0);
        if (len == 0) begin
            check("load0_wready", hif.host_wready, 0);
            @(negedge clk);
            expect_done();
            return;
        end
        for (int i = 0; i < len; i++) begin
            g = rnd ? int'($urandom_range(0, 2)) : ((i == gap_idx) ? gap_n : 0);
            repeat (g) begin
                @(negedge clk);
                check("load_gap_no_write", core_setup_mem, 0);
            end
            check("load_wready", hif.host_wready, 1);
            a = (base + i) % DEPTH;
            d = rnd ? {$urandom, $urandom} : DATA_W'(64'hA + 64'(i));
            hif.host_wdata  = d;
            hif.host_wvalid = 1'b1;
            @(negedge clk);
            hif.host_wvalid = 1'b0;
            check("load_write_pulse", core_setup_mem, 1);
            check("load_write_addr", core_mem_addr, a);
            check("load_write_data", core_mem_data, d);
            ref_mem[a] = d;
        end
        check("load_wready_fin", hif.host_wready, 0);
        @(negedge clk);
        check("load_pulse_ends", core_setup_mem, 0);
        expect_done();
    endtask

    task automatic do_run(input int n);
        issue(CMD_RUN, 0, 0, n);
        check("run_ready_low", hif.host_cmd_ready, 0);
        for (int j = 0; j < n; j++) begin
            check("run_en_high", core_en, 1);
            check("run_no_done", done, 0);
            @(negedge clk);
        end
        if (n == 0) begin
            check("run0_en_low", core_en, 0);
            @(negedge clk);
        end
        check("run_en_drops", core_en, 0);
        expect_done();
    endtask

    task automatic do_dump(input int base, input int len, input int stall0, input bit rnd,
                           input bit noise);
        int a, waited, s;
        logic [DATA_W-1:0] held;
        issue(CMD_DUMP, base, len, 0);
        if (len == 0) begin
            check("dump0_no_verify", core_verify_mem, 0);
            @(negedge clk);
            expect_done();
            return;
        end
        for (int i = 0; i < len; i++) begin
            a = (base + i) % DEPTH;
            check("dump_issue_verify", core_verify_mem, 1);
            check("dump_issue_addr", core_mem_addr, a);
            check("dump_issue_rvalid_low", hif.host_rvalid, 0);
            waited = 0;
            while (!hif.host_rvalid && waited < 8) begin
                hif.host_cmd_valid = noise & $urandom_range(0, 1);
                hif.host_cmd       = CMD_LOAD;
                hif.host_len       = ADDR_W'($urandom_range(1, 4));
                @(negedge clk);
                waited++;
                check("dump_ready_low", hif.host_cmd_ready, 0);
                if (!hif.host_rvalid) begin
                    check("dump_wait_verify", core_verify_mem, 1);
                    check("dump_wait_addr", core_mem_addr, a);
                end
            end
            hif.host_cmd_valid = 1'b0;
            check("dump_read_latency", 64'(waited), 64'(1 + RD_LAT));
            if (!hif.host_rvalid) begin
                resync();
                return;
            end
            check("dump_rdata", hif.host_rdata, ref_mem[a]);
            held = ref_mem[a];
            s = rnd ? int'($urandom_range(0, 3)) : ((i == 0) ? stall0 : 0);
            repeat (s) begin
                hif.host_cmd_valid = noise;
                hif.host_cmd       = CMD_LOAD;
                hif.host_len       = ADDR_W'(2);
                @(negedge clk);
                check("dump_hold_rvalid", hif.host_rvalid, 1);
                check("dump_hold_rdata", hif.host_rdata, held);
                check("dump_hold_ready_low", hif.host_cmd_ready, 0);
            end
            hif.host_cmd_valid = 1'b0;
            hif.host_rready    = 1'b1;
            @(negedge clk);
            hif.host_rready    = 1'b0;
            check("dump_rvalid_drops", hif.host_rvalid, 0);
        end
        check("dump_fin_no_verify", core_verify_mem, 0);
        @(negedge clk);
        expect_done();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int op;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = DATA_W'(i) ^ 64'h55;
        clear_inputs();
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ready", hif.host_cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", core_en, 0);
        check("rst_setup", core_setup_mem, 0);
        check("rst_verify", core_verify_mem, 0);
        check("rst_addr", core_mem_addr, 0);
        check("rst_data", core_mem_data, 0);
        check("rst_wready", hif.host_wready, 0);
        check("rst_rvalid", hif.host_rvalid, 0);
        check("rst_rdata", hif.host_rdata, 0);
        reset  = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);

        // Directed scenarios
        do_load(0, 3, 1, 2, 1'b0);
        do_load(1022, 4, 0, 0, 1'b1);
        do_run(7);
        do_run(0);
        do_dump(512, 2, 3, 1'b0, 1'b1);
        do_dump(1022, 4, 0, 1'b1, 1'b0);
        do_run(1);

        // NOP is accepted without any effect
        issue(CMD_NOP, 5, 5, 5);
        check("nop_busy", busy, 0);
        check("nop_ready", hif.host_cmd_ready, 1);
        check("nop_no_done", done, 0);
        @(negedge clk);
        check("nop_no_done_later", done, 0);

        // Reset in the middle of a long RUN
        issue(CMD_RUN, 0, 0, 50);
        repeat (10) @(negedge clk);
        check("midrun_en", core_en, 1);
        reset = 1'b0;
        @(negedge clk);
        check("midrun_rst_en", core_en, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_ready", hif.host_cmd_ready, 1);
        check("midrun_rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_done", done, 0);
            check("post_rst_en", core_en, 0);
            check("post_rst_ready", hif.host_cmd_ready, 1);
        end
        do_run(3);

        // Random command mix
        for (int k = 0; k < 40; k++) begin
            op = int'($urandom_range(0, 3));
            case (op)
                0: begin
                    issue(CMD_NOP, 0, 0, 0);
                    check("rnd_nop_busy", busy, 0);
                    check("rnd_nop_done", done, 0);
                end
                1: do_load(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 6)), 0, 0, 1'b1);
                2: do_run(int'($urandom_range(0, 12)));
                default: do_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 5)),
                                 0, 1'b1, 1'($urandom_range(0, 1)));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
